// File: rtl/pa_spsram_arb_pkg.sv
// Purpose : shared constants and state encoding for the pa_spsram_arb_32x47 block.
// Contents: ADDR_WIDTH / DATA_WIDTH / DEPTH of the 32x47 single-port SRAM,
//           arbiter FSM state encoding (INIT=0, RUN=1).
package pa_spsram_arb_pkg;

    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH = 47;
    localparam int unsigned DEPTH      = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pa_spsram_rr_arb2.sv
// Purpose : 2-way round-robin grant with a 1-bit pointer register.
// Ports   : i_clk        clock, rising edge
//           i_rst_n      synchronous active-low reset
//           i_enable     grants allowed this cycle
//           i_vld[1:0]   per-client request valid
//           o_gnt[1:0]   one-hot grant (combinational)
//           o_gnt_id     index of the granted client (combinational)
module pa_spsram_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [1:0] i_vld,
    output logic [1:0] o_gnt,
    output logic       o_gnt_id
);

    logic r_ptr;

    // Single requester wins outright; on a tie the pointer decides.
    always_comb begin
        o_gnt    = 2'b00;
        o_gnt_id = 1'b0;
        if (i_enable) begin
            case (i_vld)
                2'b01: begin
                    o_gnt    = 2'b01;
                    o_gnt_id = 1'b0;
                end
                2'b10: begin
                    o_gnt    = 2'b10;
                    o_gnt_id = 1'b1;
                end
                2'b11: begin
                    o_gnt    = r_ptr ? 2'b10 : 2'b01;
                    o_gnt_id = r_ptr;
                end
                default: begin
                    o_gnt    = 2'b00;
                    o_gnt_id = 1'b0;
                end
            endcase
        end
    end

    // Pointer moves to the loser only when something was granted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (|o_gnt) begin
            r_ptr <= ~o_gnt_id;
        end
    end

endmodule

// File: rtl/pa_spsram_arb_32x47.sv
// Purpose : two-client arbiter/sequencer owning all pins of the 32x47
//           single-port SRAM; one access per cycle, round-robin, read data
//           returned one cycle later tagged with the requester id.
// Config  : PA_SPSRAM_ARB_INIT_EN - when defined, zero-fill the array after
//           reset (INIT state, 32 cycles) before accepting requests.
// Ports   : forever_cpuclk / cpurst_b          clock, sync active-low reset
//           req_vld/req_rdy/req_wr[1:0]        per-client handshake and r/w
//           req{0,1}_addr/_wdata/_wmask        per-client payload
//           rsp_vld/rsp_id/rsp_data            read response (data = sram_q)
//           init_done                          array usable
//           sram_a/cen/gwen/wen/d, sram_q      SRAM macro interface
module pa_spsram_arb_32x47
    import pa_spsram_arb_pkg::*;
(
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [1:0]            req_vld,
    output logic [1:0]            req_rdy,
    input  logic [1:0]            req_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  rsp_vld,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  w_run;
    logic                  w_init_wr;
    logic [ADDR_WIDTH-1:0] w_init_a;
    logic [1:0]            w_gnt;
    logic                  w_gnt_id;
    logic                  w_xfer;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_wmask;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_rsp_vld;
    logic                  r_rsp_id;

`ifdef PA_SPSRAM_ARB_INIT_EN
    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_addr;

    // State register.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leave INIT once the last entry has been written.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_addr == ADDR_WIDTH'(DEPTH - 1)) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
        endcase
    end

    // State decode; everything is held idle while reset is asserted.
    always_comb begin
        w_run     = 1'b0;
        w_init_wr = 1'b0;
        w_init_a  = r_init_addr;
        if (cpurst_b) begin
            case (r_state)
                ST_INIT: w_init_wr = 1'b1;
                ST_RUN:  w_run     = 1'b1;
            endcase
        end
    end

    // Zero-fill sweep address.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_init_addr <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
        end
    end

    assign init_done = (r_state == ST_RUN);
`else
    assign w_run     = cpurst_b;
    assign w_init_wr = 1'b0;
    assign w_init_a  = '0;
    assign init_done = 1'b1;
`endif

    pa_spsram_rr_arb2 u_rr_arb (
        .i_clk    (forever_cpuclk),
        .i_rst_n  (cpurst_b),
        .i_enable (w_run),
        .i_vld    (req_vld),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign req_rdy = w_gnt;
    assign w_xfer  = |(req_vld & w_gnt);
    assign w_wr    = w_gnt_id ? req_wr[1]  : req_wr[0];
    assign w_addr  = w_gnt_id ? req1_addr  : req0_addr;
    assign w_wdata = w_gnt_id ? req1_wdata : req0_wdata;
    assign w_wmask = w_gnt_id ? req1_wmask : req0_wmask;

    // Address is parked on the last granted entry between accesses.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_last_addr <= '0;
        end else if (w_xfer) begin
            r_last_addr <= w_addr;
        end
    end

    // SRAM pin drive; an all-zero write mask becomes a harmless read cycle.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = r_last_addr;
        sram_d    = '0;
        if (w_init_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = w_init_a;
        end else if (w_xfer) begin
            sram_cen = 1'b0;
            sram_a   = w_addr;
            if (w_wr) begin
                sram_d    = w_wdata;
                sram_wen  = ~w_wmask;
                sram_gwen = (w_wmask == '0);
            end
        end
    end

    // Read response tracking; SRAM Q arrives one cycle after the access.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= 1'b0;
        end else begin
            r_rsp_vld <= w_xfer & ~w_wr;
            if (w_xfer & ~w_wr) begin
                r_rsp_id <= w_gnt_id;
            end
        end
    end

    assign rsp_vld  = r_rsp_vld;
    assign rsp_id   = r_rsp_id;
    assign rsp_data = sram_q;

endmodule

// File: doc/pa_spsram_arb_32x47.md
# pa_spsram_arb_32x47

Two-requester arbiter and sequencer for the 32-entry × 47-bit single-port SRAM (`pa_f_spsram_32x47`). It accepts read and masked-write requests from two independent clients over valid/ready handshakes and grants at most one SRAM access per cycle, round-robin. It returns read data tagged with the requester ID and, optionally, zero-fills the array after reset. It sits directly between the SRAM instance and the client pipelines, and owns every SRAM control pin.

## Interface
- ADDR_WIDTH, 5: SRAM address width
- DATA_WIDTH, 47: SRAM data width
- DEPTH, 32: number of entries (2^ADDR_WIDTH)
- forever_cpuclk  in  1  clock; all logic on rising edge
- cpurst_b  in  1  reset, synchronous, active-low
- req_vld[1:0]  in  2  per-client request valid
- req_rdy[1:0]  out  2  per-client request ready (grant)
- req_wr[1:0]  in  2  per-client 1=write, 0=read
- req0_addr / req1_addr  in  ADDR_WIDTH each  per-client address
- req0_wdata / req1_wdata  in  DATA_WIDTH each  per-client write data
- req0_wmask / req1_wmask  in  DATA_WIDTH each  per-client bit write-enable, active-high
- rsp_vld  out  1  read data valid
- rsp_id  out  1  requester that issued the read
- rsp_data  out  DATA_WIDTH  read data
- init_done  out  1  array usable
- sram_a  out  ADDR_WIDTH  to SRAM A
- sram_cen  out  1  to SRAM CEN, active-low
- sram_gwen  out  1  to SRAM GWEN, active-low
- sram_wen  out  DATA_WIDTH  to SRAM WEN, active-low per bit
- sram_d  out  DATA_WIDTH  to SRAM D
- sram_q  in  DATA_WIDTH  from SRAM Q

## Operation
- States: INIT, RUN. After reset the block enters INIT if the macro is defined, otherwise RUN.
- INIT
  - Counter `init_addr` runs 0→31, one write per cycle: D=0, WEN=all 0, GWEN=0, CEN=0.
  - After addr 31 is written, the FSM moves to RUN and init_done rises.
  - req_rdy=0 throughout INIT.
- RUN: a client is eligible when its req_vld is high.
  - One eligible client: it is granted.
  - Both eligible: the client pointed to by the 1-bit round-robin pointer `rr_ptr` is granted.
  - `rr_ptr` updates to the non-granted client only when a grant occurs. Its reset value is 0.
- req_rdy[i] is combinational and is high only for the granted client. A transfer occurs when req_vld[i] & req_rdy[i].
- SRAM drive on a transfer (same cycle, combinational): CEN=0, A=addr.
  - Write: D=wdata, WEN=~wmask, GWEN=(wmask==0).
  - Read: GWEN=1, WEN=all 1.
- No transfer: CEN=1, GWEN=1, WEN=all 1, A=last granted address, D=0.
- Write with all-zero mask: accepted, no bits change, no response.
- Read response: rsp_vld=1 exactly one cycle after the read transfer, with rsp_id=granted client and rsp_data=sram_q in that cycle. There is no backpressure on the response path; clients must sink it.
- Back-to-back reads are permitted every cycle. rsp_data is valid only while rsp_vld=1.
- A read of an address written in the immediately preceding cycle returns the new data.

## Timing
- Reset values: req_rdy=0, rsp_vld=0, rsp_id=0, rsp_data don't-care, init_done=0 (macro defined) or 1 (macro undefined), sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- Grant latency is 0 cycles; req_rdy depends on req_vld within the same cycle.
- Read latency is 1 cycle, transfer edge to rsp_vld.
- Write takes effect at the transfer edge.
- Throughput is 1 access per cycle.
- INIT duration is exactly DEPTH cycles after the reset deassertion edge.
- Reset asserted mid-INIT: init_addr returns to 0 and the full 32-entry sweep restarts.
- Reset asserted with a read in flight: that response is dropped and rsp_vld=0 on the next edge.
- Both clients request continuously: grants alternate 0,1,0,1…

## Configuration
- PA_SPSRAM_ARB_INIT_EN
  - Defined: INIT state and zero-fill sweep present; init_done follows the INIT sequence.
  - Undefined: INIT logic and counter are removed, init_done is tied to 1, and grants are possible from the first cycle after reset.

## Structure
- Shared package/header pa_spsram_arb_pkg: state encoding (INIT=1'b0, RUN=1'b1) and the DEPTH/ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module, pa_spsram_rr_arb2: 2-way round-robin grant with pointer register. Inputs are enable, vld[1:0]; outputs are gnt[1:0] and gnt_id.
- The SRAM is instantiated outside this block.

## Test plan
- Reset with PA_SPSRAM_ARB_INIT_EN, no requests → 32 consecutive CEN=0/GWEN=0 writes at addr 0..31 with D=0. init_done rises in cycle 33, and a read of addr 17 then returns 0.
- Client0 writes addr 5, data 0x7FFF_FFFF_FFFF, full mask; next cycle client1 reads addr 5 → rsp_vld one cycle later, rsp_id=1, rsp_data=0x7FFF_FFFF_FFFF.
- Addr 9 holds all 1s; write 0 with mask=0x0000_0000_00FF, then read 9 → rsp_data=0x7FFF_FFFF_FF00. A write with mask=0 afterwards leaves 0x7FFF_FFFF_FF00.
- Both clients hold req_vld=1 reading addr 1 and 2 for 6 cycles → grants 0,1,0,1,0,1. rsp_id alternates with matching data, and neither client waits more than 1 cycle.
- Reset pulsed at INIT cycle 10 → sweep restarts at addr 0, and init_done rises 32 cycles after the second reset release.
- Reset pulsed in the cycle after a read transfer → rsp_vld stays 0, and all SRAM pins return to their idle values.
